// File: rtl/device_bus_arbiter.sv
// rtl/device_bus_arbiter.sv - cluster device bus initiator with per-core request arbitration
//
// Collects device read/write requests from up to NUM_CORES cores, grants one at a
// time and runs it through a fixed IDLE -> ISSUE -> RESP sequence. The granted
// request drives the shared device bus. The responder's registered read data is
// returned to the granted core with a one-cycle acknowledge.
//
// Optional feature macro: DEVICE_ARB_ROUND_ROBIN_EN
//   defined   : round-robin arbitration from a rotating pointer
//   undefined : fixed priority, lowest-index eligible core wins
//
// Ports:
//   clk              clock
//   reset_n          asynchronous active-low reset
//   core_req         per-core request, held with its attributes until its ack
//   core_write       per-core direction (1 = write, 0 = read)
//   core_addr        per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   core_wdata       per-core write data, core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   core_ack         one-hot, one-cycle completion pulse
//   core_rdata       read data, valid in the ack cycle
//   device_core_id   index of the granted core
//   device_write_en  write strobe (single cycle)
//   device_read_en   read strobe (single cycle)
//   device_addr      device address
//   device_data_out  device write data
//   device_data_in   responder read data, registered by responder on strobe edge

module device_bus_arbiter #(
   parameter int NUM_CORES  = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_CORES-1:0]             core_req,
   input  logic [NUM_CORES-1:0]             core_write,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
   input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wdata,
   output logic [NUM_CORES-1:0]             core_ack,
   output logic [DATA_WIDTH-1:0]            core_rdata,
   output logic [2:0]                       device_core_id,
   output logic                             device_write_en,
   output logic                             device_read_en,
   output logic [ADDR_WIDTH-1:0]            device_addr,
   output logic [DATA_WIDTH-1:0]            device_data_out,
   input  logic [DATA_WIDTH-1:0]            device_data_in
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [NUM_CORES-1:0]    elig;
   logic                    found;
   logic [2:0]              win;
   logic                    win_write;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_wdata;
   logic                    is_write;

   // A core whose ack is showing this cycle still has its request up; hide it
   // so the same transaction is not granted twice.
   assign elig = core_req & ~core_ack;

`ifdef DEVICE_ARB_ROUND_ROBIN_EN
   logic [2:0] ptr;
   logic [3:0] cand;

   // Search starts at the pointer and wraps modulo NUM_CORES.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand = {1'b0, ptr} + 4'(k);
         if (cand >= 4'(NUM_CORES))
            cand = cand - 4'(NUM_CORES);
         if (!found && elig[cand[2:0]]) begin
            found = 1'b1;
            win   = cand[2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr <= '0;
      else if (state == IDLE && found)
         ptr <= (win == 3'(NUM_CORES - 1)) ? 3'd0 : win + 3'd1;
   end
`else
   // Scan from the top down so the lowest eligible index is the last write.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (elig[i]) begin
            found = 1'b1;
            win   = 3'(i);
         end
      end
   end
`endif

   // Attributes of the winning core.
   always_comb begin
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (win == 3'(i)) begin
            win_write = core_write[i];
            win_addr  = core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = core_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered bus outputs. Strobes and ack default low every cycle, so each
   // is a single-cycle pulse by construction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_ack        <= '0;
         core_rdata      <= '0;
         device_core_id  <= '0;
         device_write_en <= 1'b0;
         device_read_en  <= 1'b0;
         device_addr     <= '0;
         device_data_out <= '0;
         is_write        <= 1'b0;
      end else begin
         core_ack        <= '0;
         device_write_en <= 1'b0;
         device_read_en  <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  device_core_id  <= win;
                  device_addr     <= win_addr;
                  device_data_out <= win_wdata;
                  is_write        <= win_write;
                  device_write_en <= win_write;
                  device_read_en  <= !win_write;
               end
            end
            RESP: begin
               // Responder data registered on the strobe edge is valid now.
               if (!is_write)
                  core_rdata <= device_data_in;
               core_ack[device_core_id] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_device_bus_arbiter.sv
// tb/tb_device_bus_arbiter.sv - directed self-checking bench for device_bus_arbiter

module tb_device_bus_arbiter;

   localparam int NC = 8;
   localparam int AW = 10;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NC-1:0]     core_req;
   logic [NC-1:0]     core_write;
   logic [NC*AW-1:0]  core_addr;
   logic [NC*DW-1:0]  core_wdata;
   logic [NC-1:0]     core_ack;
   logic [DW-1:0]     core_rdata;
   logic [2:0]        device_core_id;
   logic              device_write_en;
   logic              device_read_en;
   logic [AW-1:0]     device_addr;
   logic [DW-1:0]     device_data_out;
   logic [DW-1:0]     device_data_in;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   device_bus_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .core_req        (core_req),
      .core_write      (core_write),
      .core_addr       (core_addr),
      .core_wdata      (core_wdata),
      .core_ack        (core_ack),
      .core_rdata      (core_rdata),
      .device_core_id  (device_core_id),
      .device_write_en (device_write_en),
      .device_read_en  (device_read_en),
      .device_addr     (device_addr),
      .device_data_out (device_data_out),
      .device_data_in  (device_data_in)
   );

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      core_req       = '0;
      core_write     = '0;
      core_addr      = '0;
      core_wdata     = '0;
      device_data_in = '0;
      reset_n        = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   int g[4];
   int exp_g[4];
   int n;
   logic prev_stb;
   logic cur_stb;

   initial begin
      do_reset();

      // Reset state after 5 idle cycles.
      repeat (5) tick();
      expect_eq("rst_ack",   core_ack, 0);
      expect_eq("rst_rdata", core_rdata, 0);
      expect_eq("rst_id",    device_core_id, 0);
      expect_eq("rst_wen",   device_write_en, 0);
      expect_eq("rst_ren",   device_read_en, 0);
      expect_eq("rst_addr",  device_addr, 0);
      expect_eq("rst_dout",  device_data_out, 0);

      // Write from core 3; attributes changed after grant must be ignored.
      core_req[3]           = 1'b1;
      core_write[3]         = 1'b1;
      core_addr[3*AW +: AW] = 10'h3ff;
      core_wdata[3*DW +: DW] = 16'h1234;
      tick();                                   // cycle 1
      expect_eq("wr_wen",  device_write_en, 1);
      expect_eq("wr_ren",  device_read_en, 0);
      expect_eq("wr_addr", device_addr, 10'h3ff);
      expect_eq("wr_dout", device_data_out, 16'h1234);
      expect_eq("wr_id",   device_core_id, 3);
      core_addr[3*AW +: AW]  = 10'h000;
      core_wdata[3*DW +: DW] = 16'hffff;
      tick();                                   // cycle 2
      expect_eq("wr_c2_wen",  device_write_en, 0);
      expect_eq("wr_c2_addr", device_addr, 10'h3ff);
      expect_eq("wr_c2_ack",  core_ack, 0);
      tick();                                   // cycle 3
      expect_eq("wr_ack",   core_ack, 8'b0000_1000);
      expect_eq("wr_rdata", core_rdata, 0);
      core_req = '0;
      core_write = '0;
      tick();                                   // cycle 4
      expect_eq("wr_ack_gone", core_ack, 0);
      expect_eq("wr_no_regrant", device_write_en, 0);
      repeat (2) tick();

      // Read from core 2; responder data valid only in the cycle after the strobe.
      core_req[2]           = 1'b1;
      core_addr[2*AW +: AW] = 10'h3fe;
      device_data_in        = 16'haaaa;
      tick();                                   // cycle 1
      expect_eq("rd_ren",  device_read_en, 1);
      expect_eq("rd_wen",  device_write_en, 0);
      expect_eq("rd_id",   device_core_id, 2);
      expect_eq("rd_addr", device_addr, 10'h3fe);
      @(posedge clk);
      #1 device_data_in = 16'h0001;
      tick();                                   // cycle 2
      expect_eq("rd_c2_ren", device_read_en, 0);
      tick();                                   // cycle 3
      expect_eq("rd_ack",   core_ack, 8'b0000_0100);
      expect_eq("rd_rdata", core_rdata, 16'h0001);
      core_req       = '0;
      device_data_in = 16'hbbbb;
      repeat (3) tick();

      // Arbitration among cores 2, 5 and 6 holding requests continuously.
`ifdef DEVICE_ARB_ROUND_ROBIN_EN
      exp_g = '{2, 5, 6, 2};
`else
      exp_g = '{2, 5, 2, 5};
`endif
      do_reset();
      core_req = 8'b0110_0100;
      n        = 0;
      prev_stb = 1'b0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         cur_stb = device_read_en | device_write_en;
         expect_eq("no_b2b_strobe", {31'b0, prev_stb & cur_stb}, 0);
         if (cur_stb) begin
            g[n] = int'(device_core_id);
            n++;
         end
         prev_stb = cur_stb;
      end
      expect_eq("arb_count", n, 4);
      for (int i = 0; i < 4; i++)
         if (i < n)
            expect_eq($sformatf("arb_grant%0d", i), g[i], exp_g[i]);
      core_req = '0;
      repeat (5) tick();

      // Reset while a read strobe is up; in-flight request is dropped.
      do_reset();
      core_req[5]           = 1'b1;
      core_addr[5*AW +: AW] = 10'h055;
      tick();                                   // cycle 1
      expect_eq("mid_ren_before", device_read_en, 1);
      expect_eq("mid_id_before",  device_core_id, 5);
      #2 reset_n = 1'b0;
      #1;
      expect_eq("mid_ren_async",  device_read_en, 0);
      expect_eq("mid_id_async",   device_core_id, 0);
      expect_eq("mid_addr_async", device_addr, 0);
      core_req              = 8'b0100_0010;
      core_addr[1*AW +: AW] = 10'h101;
      core_addr[6*AW +: AW] = 10'h206;
      tick();
      expect_eq("mid_ack_in_rst", core_ack, 0);
      reset_n = 1'b1;
      tick();                                   // cycle 1 after release
      expect_eq("mid_regrant_ren", device_read_en, 1);
      expect_eq("mid_regrant_id",  device_core_id, 1);
      expect_eq("mid_ack_c1",      core_ack, 0);
      tick();                                   // cycle 2
      expect_eq("mid_ack_c2",      core_ack, 0);
      tick();                                   // cycle 3
      expect_eq("mid_ack_c3",      core_ack, 8'b0000_0010);
      core_req = '0;
      repeat (5) tick();

      // Back-to-back: core 0 read then core 7 write.
      do_reset();
      core_req               = 8'b1000_0001;
      core_write[7]          = 1'b1;
      core_addr[0*AW +: AW]  = 10'h011;
      core_addr[7*AW +: AW]  = 10'h2a5;
      core_wdata[7*DW +: DW] = 16'hc0de;
      device_data_in         = 16'hbeef;
      tick();                                   // cycle 1
      expect_eq("b2b_ren_c1", device_read_en, 1);
      expect_eq("b2b_id_c1",  device_core_id, 0);
      expect_eq("b2b_addr_c1", device_addr, 10'h011);
      tick();                                   // cycle 2
      expect_eq("b2b_stb_c2", {31'b0, device_read_en | device_write_en}, 0);
      tick();                                   // cycle 3
      expect_eq("b2b_ack_c3",   core_ack, 8'b0000_0001);
      expect_eq("b2b_rdata_c3", core_rdata, 16'hbeef);
      expect_eq("b2b_stb_c3", {31'b0, device_read_en | device_write_en}, 0);
      core_req[0]    = 1'b0;
      device_data_in = 16'h1111;
      tick();                                   // cycle 4
      expect_eq("b2b_wen_c4",  device_write_en, 1);
      expect_eq("b2b_id_c4",   device_core_id, 7);
      expect_eq("b2b_addr_c4", device_addr, 10'h2a5);
      expect_eq("b2b_dout_c4", device_data_out, 16'hc0de);
      expect_eq("b2b_ack_c4",  core_ack, 0);
      tick();                                   // cycle 5
      expect_eq("b2b_stb_c5", {31'b0, device_read_en | device_write_en}, 0);
      tick();                                   // cycle 6
      expect_eq("b2b_ack_c6",   core_ack, 8'b1000_0000);
      expect_eq("b2b_rdata_c6", core_rdata, 16'hbeef);
      core_req = '0;
      tick();                                   // cycle 7
      expect_eq("b2b_ack_c7", core_ack, 0);
      expect_eq("b2b_stb_c7", {31'b0, device_read_en | device_write_en}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
